alu_writeback_stage: RTL and testbench

Pipeline stage directly downstream of the 19-bit ALU. It captures each ALU result with its destination register and flags, buffers it in a 2-entry FIFO with valid/ready on both sides, and retires entries in order to the register-file write port. It owns the architectural status flags: last retired zero flag, sticky divide-by-zero flag and a saturating divide-by-zero event counter.

---
 rtl/alu_writeback_stage_if.sv | 26 ++
 rtl/alu_writeback_stage.sv | 96 +++++++++
 tb/tb_alu_writeback_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_writeback_stage_if.sv
// rtl/alu_writeback_stage_if.sv - ALU result intake and register-file write handshake bundle
interface alu_writeback_stage_if #(
    parameter int DATA_W  = 19,
    parameter int RADDR_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] in_rd;
    logic [DATA_W-1:0]  in_result;
    logic               in_zero;
    logic               in_dbz;
    logic               wb_en;
    logic               wb_ready;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;

    modport master (
        output in_valid, in_rd, in_result, in_zero, in_dbz, wb_ready,
        input  in_ready, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_rd, in_result, in_zero, in_dbz, wb_ready,
        output in_ready, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - 2-entry writeback FIFO with zero/divide-by-zero status tracking
module alu_writeback_stage #(
    parameter int DATA_W  = 19,
    parameter int RADDR_W = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_writeback_stage_if.slave bus,
    output logic             status_zero,
    output logic             status_dbz,
    output logic [CNT_W-1:0] dbz_count,
    input  logic             clear_status,
    output logic             busy
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]         count;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [RADDR_W-1:0] rd_mem   [2];
    logic [DATA_W-1:0]  data_mem [2];
    logic               zero_mem [2];

    logic accept;
    logic push;
    logic r0_drop;
    logic dbz_evt;
    logic retire;

    // Ready depends only on registered occupancy: a full FIFO never passes through.
    assign bus.in_ready = (count != 2'd2);
    assign bus.wb_en    = (count != 2'd0);
    assign bus.wb_addr  = rd_mem[rd_ptr];
    assign bus.wb_data  = data_mem[rd_ptr];
    assign busy         = (count != 2'd0);

    assign accept  = bus.in_valid & bus.in_ready;
    assign dbz_evt = accept & bus.in_dbz;
    assign r0_drop = accept & ~bus.in_dbz & (bus.in_rd == '0);
    assign push    = accept & ~bus.in_dbz & (bus.in_rd != '0);
    assign retire  = bus.wb_en & bus.wb_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                rd_mem[i]   <= '0;
                data_mem[i] <= '0;
                zero_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                rd_mem[wr_ptr]   <= bus.in_rd;
                data_mem[wr_ptr] <= bus.in_result;
                zero_mem[wr_ptr] <= bus.in_zero;
                wr_ptr           <= ~wr_ptr;
            end
            if (retire) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, retire};
        end
    end

    // A dropped r0 result is newer than the head being retired, so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_zero <= 1'b0;
        end else if (r0_drop) begin
            status_zero <= bus.in_zero;
        end else if (retire) begin
            status_zero <= zero_mem[rd_ptr];
        end
    end

    // A divide-by-zero event in the same cycle as clear_status survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_dbz <= 1'b0;
            dbz_count  <= '0;
        end else if (dbz_evt) begin
            status_dbz <= 1'b1;
            if (clear_status) begin
                dbz_count <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (dbz_count != CNT_MAX) begin
                dbz_count <= dbz_count + 1'b1;
            end
        end else if (clear_status) begin
            status_dbz <= 1'b0;
            dbz_count  <= '0;
        end
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb/tb_alu_writeback_stage.sv - directed table-driven bench for alu_writeback_stage
module tb_alu_writeback_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic       clear_status;
    logic       status_zero;
    logic       status_dbz;
    logic [7:0] dbz_count;
    logic       busy;

    int cmps = 0;
    int errs = 0;

    alu_writeback_stage_if #(.DATA_W(19), .RADDR_W(3)) bus ();

    alu_writeback_stage #(.DATA_W(19), .RADDR_W(3), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .status_zero  (status_zero),
        .status_dbz   (status_dbz),
        .dbz_count    (dbz_count),
        .clear_status (clear_status),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  rd;
        logic [18:0] res;
        logic        z;
        logic        dbz;
        logic        wbr;
        logic        clr;
        logic        e_en;
        logic [2:0]  e_addr;
        logic [18:0] e_data;
        logic        e_rdy;
        logic        e_busy;
        logic        e_sz;
        logic        e_sdbz;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [2:0] rd, input logic [18:0] res,
                       input logic z, input logic dbz, input logic wbr, input logic clr,
                       input logic e_en, input logic [2:0] e_addr, input logic [18:0] e_data,
                       input logic e_rdy, input logic e_busy, input logic e_sz,
                       input logic e_sdbz, input logic [7:0] e_cnt);
        vec_t t;
        t = '{v, rd, res, z, dbz, wbr, clr, e_en, e_addr, e_data, e_rdy, e_busy, e_sz, e_sdbz, e_cnt};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] rd, input logic [18:0] res,
                         input logic z, input logic dbz, input logic wbr, input logic clr);
        bus.in_valid  = v;
        bus.in_rd     = rd;
        bus.in_result = res;
        bus.in_zero   = z;
        bus.in_dbz    = dbz;
        bus.wb_ready  = wbr;
        clear_status  = clr;
    endtask

    task automatic apply(input int idx, input vec_t t);
        string p;
        p = $sformatf("v%0d", idx);
        drive(t.v, t.rd, t.res, t.z, t.dbz, t.wbr, t.clr);
        @(posedge clk);
        #1;
        chk({p, ".wb_en"}, {31'b0, bus.wb_en}, {31'b0, t.e_en});
        if (t.e_en) begin
            chk({p, ".wb_addr"}, {29'b0, bus.wb_addr}, {29'b0, t.e_addr});
            chk({p, ".wb_data"}, {13'b0, bus.wb_data}, {13'b0, t.e_data});
        end
        chk({p, ".in_ready"}, {31'b0, bus.in_ready}, {31'b0, t.e_rdy});
        chk({p, ".busy"}, {31'b0, busy}, {31'b0, t.e_busy});
        chk({p, ".status_zero"}, {31'b0, status_zero}, {31'b0, t.e_sz});
        chk({p, ".status_dbz"}, {31'b0, status_dbz}, {31'b0, t.e_sdbz});
        chk({p, ".dbz_count"}, {24'b0, dbz_count}, {24'b0, t.e_cnt});
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 19'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.wb_en", {31'b0, bus.wb_en}, 32'd0);
        chk("reset.wb_addr", {29'b0, bus.wb_addr}, 32'd0);
        chk("reset.wb_data", {13'b0, bus.wb_data}, 32'd0);
        chk("reset.in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("reset.busy", {31'b0, busy}, 32'd0);
        chk("reset.status", {29'b0, status_zero, status_dbz, 1'b0}, 32'd0);
        chk("reset.dbz_count", {24'b0, dbz_count}, 32'd0);

        //   v  rd    res        z  dbz wbr clr | en addr data       rdy busy sz sdbz cnt
        add(1, 3'd3, 19'h00012, 0, 0, 1, 0,   1, 3'd3, 19'h00012, 1, 1, 0, 0, 8'd0);
        add(0, 3'd0, 19'h00000, 0, 0, 1, 0,   0, 3'd0, 19'h00000, 1, 0, 0, 0, 8'd0);
        add(1, 3'd1, 19'h00005, 0, 0, 0, 0,   1, 3'd1, 19'h00005, 1, 1, 0, 0, 8'd0);
        add(1, 3'd2, 19'h7FFFE, 0, 0, 0, 0,   1, 3'd1, 19'h00005, 0, 1, 0, 0, 8'd0);
        add(1, 3'd6, 19'h00011, 0, 0, 0, 0,   1, 3'd1, 19'h00005, 0, 1, 0, 0, 8'd0);
        add(1, 3'd6, 19'h00011, 0, 0, 1, 0,   1, 3'd2, 19'h7FFFE, 1, 1, 0, 0, 8'd0);
        add(0, 3'd0, 19'h00000, 0, 0, 1, 0,   0, 3'd0, 19'h00000, 1, 0, 0, 0, 8'd0);
        add(1, 3'd4, 19'h7FFFF, 0, 1, 1, 0,   0, 3'd0, 19'h00000, 1, 0, 0, 1, 8'd1);
        add(1, 3'd4, 19'h7FFFF, 0, 1, 1, 0,   0, 3'd0, 19'h00000, 1, 0, 0, 1, 8'd2);
        add(1, 3'd4, 19'h7FFFF, 0, 1, 1, 0,   0, 3'd0, 19'h00000, 1, 0, 0, 1, 8'd3);
        add(1, 3'd4, 19'h7FFFF, 0, 1, 1, 1,   0, 3'd0, 19'h00000, 1, 0, 0, 1, 8'd1);
        add(0, 3'd0, 19'h00000, 0, 0, 1, 1,   0, 3'd0, 19'h00000, 1, 0, 0, 0, 8'd0);
        add(1, 3'd0, 19'h00000, 1, 0, 1, 0,   0, 3'd0, 19'h00000, 1, 0, 1, 0, 8'd0);
        add(1, 3'd5, 19'h00007, 0, 0, 0, 0,   1, 3'd5, 19'h00007, 1, 1, 1, 0, 8'd0);
        add(0, 3'd0, 19'h00000, 0, 0, 1, 0,   0, 3'd0, 19'h00000, 1, 0, 0, 0, 8'd0);
        add(1, 3'd7, 19'h00100, 1, 0, 0, 0,   1, 3'd7, 19'h00100, 1, 1, 0, 0, 8'd0);
        add(1, 3'd0, 19'h00000, 0, 0, 1, 0,   0, 3'd0, 19'h00000, 1, 0, 0, 0, 8'd0);
        add(1, 3'd6, 19'h00002, 1, 0, 0, 0,   1, 3'd6, 19'h00002, 1, 1, 0, 0, 8'd0);
        add(1, 3'd3, 19'h00003, 0, 0, 1, 0,   1, 3'd3, 19'h00003, 1, 1, 1, 0, 8'd0);
        add(0, 3'd0, 19'h00000, 0, 0, 1, 0,   0, 3'd0, 19'h00000, 1, 0, 0, 0, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Saturation: 256 back-to-back events must stop at 255.
        for (int i = 1; i <= 256; i++) begin
            drive(1'b1, 3'd4, 19'h7FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            if (i == 254 || i == 255 || i == 256) begin
                chk($sformatf("sat.dbz_count@%0d", i), {24'b0, dbz_count},
                    (i >= 255) ? 32'd255 : 32'd254);
            end
        end
        chk("sat.status_dbz", {31'b0, status_dbz}, 32'd1);
        chk("sat.wb_en", {31'b0, bus.wb_en}, 32'd0);

        // Fill the FIFO with stalled writes, then reset mid-transfer.
        drive(1'b1, 3'd0, 19'h00000, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 3'd1, 19'h0000A, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 3'd2, 19'h0000B, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("full.in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("full.status_zero", {31'b0, status_zero}, 32'd1);
        chk("full.head", {29'b0, bus.wb_addr}, 32'd1);
        drive(1'b0, 3'd0, 19'h00000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2.wb_en", {31'b0, bus.wb_en}, 32'd0);
        chk("rst2.busy", {31'b0, busy}, 32'd0);
        chk("rst2.in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst2.status_zero", {31'b0, status_zero}, 32'd0);
        chk("rst2.status_dbz", {31'b0, status_dbz}, 32'd0);
        chk("rst2.dbz_count", {24'b0, dbz_count}, 32'd0);
        chk("rst2.wb_addr", {29'b0, bus.wb_addr}, 32'd0);
        chk("rst2.wb_data", {13'b0, bus.wb_data}, 32'd0);
        drive(1'b0, 3'd0, 19'h00000, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst.wb_en@%0d", i), {31'b0, bus.wb_en}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
